// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 7-segment driver: snapshots packed BCD digits once per frame,
// scans them one digit per slot with a blanked guard interval at each slot start.
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16,
  parameter bit AN_ACT_LOW  = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      GUARD_CNT = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACT_LOW}};
  localparam logic [6:0]            SEG_OFF   = {7{SEG_ACT_LOW}};

  logic [CNT_W-1:0]        refresh_cnt;
  logic [IDX_W-1:0]        idx;
  logic                    slot_end;
  logic                    frame_end;

  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;

  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic [NUM_DIGITS-1:0]   slot_onehot;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    zero_run;
  logic                    cur_blank;
  logic                    anode_on;
  logic [6:0]              seg_on;

  // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
    logic [6:0] pattern;
    case (code)
      4'd0:    pattern = 7'h3F;
      4'd1:    pattern = 7'h06;
      4'd2:    pattern = 7'h5B;
      4'd3:    pattern = 7'h4F;
      4'd4:    pattern = 7'h66;
      4'd5:    pattern = 7'h6D;
      4'd6:    pattern = 7'h7D;
      4'd7:    pattern = 7'h07;
      4'd8:    pattern = 7'h7F;
      4'd9:    pattern = 7'h6F;
      default: pattern = 7'h40;
    endcase
    return pattern;
  endfunction

  assign slot_end  = (refresh_cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Scan position advances unconditionally; en only gates the anodes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values of the others, independent of statement order.
      if (slot_end) begin
        refresh_cnt <= '0;
        idx         <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

  // Inputs are captured only at frame end so a frame never mixes two values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the snapshot is ordinary flops, not a RAM, so it takes the
      // async reset like any other register and never shows stale garbage.
      snap_digits <= '0;
      snap_dp     <= '0;
    end else if (frame_end) begin
      snap_digits <= digits;
      snap_dp     <= dp_in;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the loop, so no path through
    // this block leaves one unassigned and no latch is inferred.
    cur_digit   = '0;
    cur_dp      = 1'b0;
    slot_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit      = snap_digits[4*i +: 4];
        cur_dp         = snap_dp[i];
        slot_onehot[i] = 1'b1;
      end
    end
  end

  // Walk down from the top digit; a digit is a leading zero while every
  // digit at or above it is a literal BCD zero. Digit 0 is never in the mask.
  always_comb begin
    zero_run   = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run      = zero_run && (snap_digits[4*i +: 4] == 4'd0);
      blank_mask[i] = zero_run;
    end
  end

  assign cur_blank = blank_lz && |(blank_mask & slot_onehot);
  assign anode_on  = en && (refresh_cnt >= GUARD_CNT);
  assign seg_on    = cur_blank ? 7'h00 : bcd_to_seg(cur_digit);

  // Polarity is applied by XOR with the "off" pattern at the output flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= SEG_ACT_LOW;
      frame_tick <= 1'b0;
    end else begin
      an         <= (anode_on ? slot_onehot : '0) ^ AN_OFF;
      seg        <= seg_on ^ SEG_OFF;
      dp         <= cur_dp ^ SEG_ACT_LOW;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: arithmetic frame model compared
// every cycle, plus directed literal checks on slot contents and timing.
module tb_seven_seg_scanner;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int GUARD = 1;
  localparam int FRAME = ND * RD;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  int          tick;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_ft;

  seven_seg_scanner #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .GUARD      (GUARD),
    .AN_ACT_LOW (1'b1),
    .SEG_ACT_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .digits    (digits),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_tick(frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: position within the frame is tick; slot = tick/RD, phase = tick%RD.
  function automatic logic [3:0] model_an(input int t, input logic e);
    logic [3:0] one;
    if (!e || (t % RD) < GUARD) return 4'hF;
    one = 4'b0001 << (t / RD);
    return ~one;
  endfunction

  function automatic logic [6:0] model_seg(input int slot, input logic [15:0] d, input logic blz);
    logic [15:0] upper;
    upper = d >> (4 * slot);
    if (blz && slot > 0 && upper == 16'h0) return 7'h7F;
    return ~SEG_TAB[upper[3:0]];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick    <= 0;
      m_dig   <= '0;
      m_dp    <= '0;
      exp_an  <= 4'hF;
      exp_seg <= 7'h7F;
      exp_dp  <= 1'b1;
      exp_ft  <= 1'b0;
    end else begin
      tick    <= (tick + 1) % FRAME;
      exp_an  <= model_an(tick, en);
      exp_seg <= model_seg(tick / RD, m_dig, blank_lz);
      exp_dp  <= ~m_dp[tick / RD];
      exp_ft  <= (tick == FRAME - 1);
      if (tick == FRAME - 1) begin
        m_dig <= digits;
        m_dp  <= dp_in;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_an", an, exp_an);
      check("cyc_seg", seg, exp_seg);
      check("cyc_dp", dp, exp_dp);
      check("cyc_tick", frame_tick, exp_ft);
    end
  end

  task automatic skip(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_ft(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 64);
    check("tick_seen", frame_tick, 1);
  endtask

  // Called on a frame_tick negedge; checks each slot's guard cycle and one
  // active cycle, and returns on the next frame_tick negedge.
  task automatic check_slots(input string tag, input logic [27:0] segs, input logic [3:0] dps);
    logic [3:0] e_an;
    for (int s = 0; s < ND; s++) begin
      skip(1);
      check({tag, "_guard"}, an, 4'hF);
      skip(1);
      e_an = ~(4'b0001 << s);
      check({tag, "_an"}, an, e_an);
      check({tag, "_seg"}, seg, segs[7*s +: 7]);
      check({tag, "_dp"}, dp, dps[s]);
      skip(2);
    end
  endtask

  initial begin
    int n;
    int m;
    rst      = 1'b1;
    en       = 1'b1;
    digits   = 16'h1234;
    dp_in    = 4'b0000;
    blank_lz = 1'b0;
    #3 rst = 1'b0;

    skip(3);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_tick", frame_tick, 1'b0);
    check_en = 1'b1;

    // First frame_tick lands 16 cycles after reset release.
    rst = 1'b1;
    wait_ft(n);
    check("first_tick_cycle", n, 16);
    check_slots("t1234", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);

    // Leading-zero blanking on, then off.
    digits   = 16'h0070;
    blank_lz = 1'b1;
    wait_ft(n);
    check_slots("lz_on", {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'hF);
    blank_lz = 1'b0;
    wait_ft(n);
    check_slots("lz_off", {7'h40, 7'h40, 7'h78, 7'h40}, 4'hF);

    // Mid-frame input change stays invisible until the next snapshot.
    digits = 16'h1234;
    wait_ft(n);
    skip(7);
    digits = 16'h5678;
    skip(3);
    check("tear_an2", an, 4'b1011);
    check("tear_seg2", seg, 7'h24);
    skip(4);
    check("tear_an3", an, 4'b0111);
    check("tear_seg3", seg, 7'h79);
    skip(2);
    check("tear_tick", frame_tick, 1'b1);
    check_slots("t5678", {7'h12, 7'h02, 7'h78, 7'h00}, 4'hF);

    // Non-BCD codes show a dash; dp lit only on digit 1.
    digits   = 16'h00AF;
    dp_in    = 4'b0010;
    blank_lz = 1'b1;
    wait_ft(n);
    check_slots("dash", {7'h7F, 7'h7F, 7'h3F, 7'h3F}, 4'b1101);

    // en dropped mid-slot: anodes off next cycle, scan keeps its position.
    wait_ft(n);
    skip(2);
    check("en_before", an, 4'b1110);
    en = 1'b0;
    skip(1);
    check("en_off", an, 4'hF);
    skip(2);
    en = 1'b1;
    skip(1);
    check("en_resume", an, 4'b1101);

    // Async reset in slot 2, then scan restarts from slot 0.
    wait_ft(n);
    skip(10);
    check("pre_rst_an", an, 4'b1011);
    #2 rst = 1'b0;
    #1;
    check("async_an", an, 4'hF);
    check("async_seg", seg, 7'h7F);
    check("async_dp", dp, 1'b1);
    skip(2);
    rst = 1'b1;
    skip(1);
    check("restart_guard", an, 4'hF);
    skip(1);
    check("restart_an", an, 4'b1110);
    check("restart_seg", seg, 7'h40);
    check("restart_dp", dp, 1'b1);
    wait_ft(m);
    check("restart_tick_cycle", m + 2, 16);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
